cs_stream_ctrl: RTL and testbench

//   Sequencer wrapping one CS core (9-sample window, 8-bit X in, 10-bit Y out) for a valid/ready streaming fabric.

---
 rtl/cs_stream_ctrl.sv | 170 +++++++++++++++++
 tb/tb_cs_stream_ctrl.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cs_stream_ctrl.sv
// Valid/ready sequencer around a windowed CS core: warm-up suppression, credit backpressure, result FIFO.
// Define CS_CTRL_STATS_EN to add the frame_cnt / drop_cnt statistics ports.
module cs_stream_ctrl #(
  parameter int unsigned CS_LAT     = 2,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned WIN        = 9
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_data,
  input  logic        in_last,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [9:0]  out_data,
  output logic [7:0]  cs_x,
  output logic        cs_en,
  output logic        cs_clr,
  input  logic [9:0]  cs_y,
  output logic        err_short
`ifdef CS_CTRL_STATS_EN
  ,
  output logic [15:0] frame_cnt,
  output logic [15:0] drop_cnt
`endif
);

  localparam int unsigned X_W    = 8;
  localparam int unsigned Y_W    = 10;
  localparam int unsigned PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned INF_W  = $clog2(CS_LAT + 2);
  localparam int unsigned SUM_W  = $clog2(FIFO_DEPTH + CS_LAT + 2) + 1;
  localparam int unsigned FILL_W = $clog2(WIN);

  typedef enum logic [1:0] {
    ST_FILL  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  state_t              state, state_d;
  logic [FILL_W-1:0]   fill_cnt, fill_d;
  logic                clr_d, short_d;

  // Tag line: stage 0 is aligned with cs_en, stage CS_LAT with the matching cs_y.
  logic [CS_LAT:0]     line_v, line_k;
  logic [INF_W-1:0]    inflight;
  logic                line_busy;

  logic [Y_W-1:0]      mem [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr, rd_ptr;
  logic [CNT_W-1:0]    fifo_cnt;

  logic                credit_ok, accept, keep, push, pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Keep-tags still travelling towards the FIFO hold a reserved slot.
  always_comb begin
    inflight = '0;
    for (int i = 0; i <= int'(CS_LAT); i++) begin
      inflight = inflight + INF_W'(line_v[i] & line_k[i]);
    end
  end

  assign line_busy = |line_v;
  assign credit_ok = (SUM_W'(fifo_cnt) + SUM_W'(inflight)) < SUM_W'(FIFO_DEPTH);
  assign in_ready  = (state != ST_FLUSH) && credit_ok && !cs_clr;
  assign accept    = in_valid && in_ready;
  assign keep      = (state == ST_RUN);
  assign push      = line_v[CS_LAT] && line_k[CS_LAT];
  assign out_valid = (fifo_cnt != '0);
  assign out_data  = mem[rd_ptr];
  assign pop       = out_valid && out_ready;
  assign cs_en     = line_v[0];

  // Next-state and registered-pulse decode.
  always_comb begin
    state_d = state;
    fill_d  = fill_cnt;
    clr_d   = 1'b0;
    short_d = 1'b0;
    unique case (state)
      ST_FILL: begin
        if (accept) begin
          fill_d = fill_cnt + FILL_W'(1);
          if (in_last) begin
            state_d = ST_FLUSH;
            short_d = 1'b1;
          end else if (fill_cnt == FILL_W'(WIN - 2)) begin
            state_d = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        if (accept && in_last) state_d = ST_FLUSH;
      end
      ST_FLUSH: begin
        if (!line_busy) begin
          state_d = ST_FILL;
          fill_d  = '0;
          clr_d   = 1'b1;
        end
      end
      default: state_d = ST_FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_FILL;
      fill_cnt  <= '0;
      cs_clr    <= 1'b1;
      err_short <= 1'b0;
      cs_x      <= '0;
      line_v    <= '0;
      line_k    <= '0;
    end else begin
      state     <= state_d;
      fill_cnt  <= fill_d;
      cs_clr    <= clr_d;
      err_short <= short_d;
      if (accept) cs_x <= in_data;
      line_v    <= {line_v[CS_LAT-1:0], accept};
      line_k    <= {line_k[CS_LAT-1:0], accept & keep};
    end
  end

  // Result FIFO; credits guarantee a push never meets a full FIFO without a pop.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      unique case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + CNT_W'(1);
        2'b01:   fifo_cnt <= fifo_cnt - CNT_W'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= cs_y;
  end

`ifdef CS_CTRL_STATS_EN
  // Saturating frame and short-frame counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      frame_cnt <= '0;
      drop_cnt  <= '0;
    end else begin
      if (clr_d && (frame_cnt != 16'hFFFF))  frame_cnt <= frame_cnt + 16'd1;
      if (short_d && (drop_cnt != 16'hFFFF)) drop_cnt  <= drop_cnt + 16'd1;
    end
  end
`endif

  logic unused_x_w;
  assign unused_x_w = (X_W == 8) ? 1'b0 : 1'b1;

endmodule

// File: tb/tb_cs_stream_ctrl.sv
// Bench for cs_stream_ctrl: behavioural windowed-sum core, frame-level result model, per-cycle compare.
`timescale 1ns/1ps
module tb_cs_stream_ctrl;
  localparam int WIN = 9;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_data = '0;
  logic       in_last = 1'b0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [9:0] out_data;
  logic [7:0] cs_x;
  logic       cs_en;
  logic       cs_clr;
  logic [9:0] cs_y = '0;
  logic       err_short;
`ifdef CS_CTRL_STATS_EN
  logic [15:0] frame_cnt;
  logic [15:0] drop_cnt;
`endif

  cs_stream_ctrl dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .cs_x(cs_x), .cs_en(cs_en), .cs_clr(cs_clr), .cs_y(cs_y),
    .err_short(err_short)
`ifdef CS_CTRL_STATS_EN
    , .frame_cnt(frame_cnt), .drop_cnt(drop_cnt)
`endif
  );

  initial forever #5 clk = ~clk;

  int n_pass = 0;
  int n_tot  = 0;

  function automatic void chk(input string name, input int act, input int exp);
    n_tot++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endfunction

  // Golden core: 9-sample window sum, result valid two cycles after cs_en.
  logic [7:0]  core_win [WIN];
  logic [9:0]  core_p1 = '0;
  logic [11:0] core_s;
  always @(posedge clk) begin
    if (cs_clr) begin
      for (int i = 0; i < WIN; i++) core_win[i] <= '0;
    end else if (cs_en) begin
      core_s = 12'(cs_x);
      for (int i = 0; i < WIN - 1; i++) core_s = core_s + 12'(core_win[i]);
      for (int i = 1; i < WIN; i++) core_win[i] <= core_win[i-1];
      core_win[0] <= cs_x;
      core_p1 <= 10'(core_s);
    end
    cs_y <= core_p1;
  end

  // Model state: accepted samples of the current frame and the expected results.
  logic [7:0] fq[$];
  int         exp_q[$];
  int         got_q[$];
  int         flen = 0;
  int         n_acc = 0, n_res = 0, n_clr = 0, n_short = 0;
  bit         prev_acc = 0, prev_short = 0, held = 0;
  int         prev_data = 0, held_data = 0;
  int         out_pct = 100;

  function automatic int win_sum();
    int s = 0;
    foreach (fq[i]) s += int'(fq[i]);
    return s % 1024;
  endfunction

  always @(negedge clk) begin
    if (reset) begin
      fq.delete(); exp_q.delete();
      flen = 0; prev_acc = 0; prev_short = 0; held = 0;
    end else begin
      chk("cs_en", int'(cs_en), int'(prev_acc));
      if (prev_acc) chk("cs_x", int'(cs_x), prev_data);
      chk("err_short", int'(err_short), int'(prev_short));
      chk("ready_during_clr", int'(in_ready & cs_clr), 0);
      if (held) begin
        chk("hold_valid", int'(out_valid), 1);
        chk("hold_data", int'(out_data), held_data);
      end
      if (out_valid) begin
        if (exp_q.size() == 0) chk("spurious_out", int'(out_valid), 0);
        else if (out_ready) begin
          chk("out_data", int'(out_data), exp_q.pop_front());
          got_q.push_back(int'(out_data));
          n_res++;
        end
      end
      held = out_valid && !out_ready;
      held_data = int'(out_data);
      if (cs_clr) n_clr++;
      if (err_short) n_short++;
      prev_acc = in_valid && in_ready;
      prev_data = int'(in_data);
      prev_short = 0;
      if (prev_acc) begin
        n_acc++;
        fq.push_back(in_data);
        flen++;
        if (fq.size() > WIN) void'(fq.pop_front());
        if (fq.size() == WIN) exp_q.push_back(win_sum());
        if (in_last) begin
          prev_short = (flen < WIN);
          fq.delete();
          flen = 0;
        end
      end
    end
  end

  initial forever begin
    @(posedge clk); #1;
    out_ready = ($urandom_range(99) < out_pct);
  end

  task automatic send(input logic [7:0] d, input logic last, input int vpct);
    int guard = 0;
    while ($urandom_range(99) >= vpct) begin
      in_valid = 1'b0; in_last = 1'b1; in_data = 8'($urandom);
      @(posedge clk); #1;
    end
    in_valid = 1'b1; in_data = d; in_last = last;
    while (!in_ready && guard < 3000) begin
      @(posedge clk); #1; guard++;
    end
    chk("accept_wait", int'(in_ready), 1);
    if (in_ready) begin
      @(posedge clk); #1;
    end
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic send_frame(input int len, input int base, input bit rnd, input int vpct);
    for (int i = 0; i < len; i++)
      send(rnd ? 8'($urandom) : 8'(base + i), (i == len - 1), vpct);
  endtask

  task automatic wait_drain();
    int guard = 0;
    repeat (6) @(negedge clk);
    while (!(exp_q.size() == 0 && !out_valid && in_ready) && guard < 5000) begin
      @(negedge clk); guard++;
    end
    chk("drain_wait", int'(guard < 5000), 1);
    @(posedge clk); #1;
  endtask

  task automatic do_reset(input int cycles);
    in_valid = 1'b0; in_last = 1'b0;
    reset = 1'b1;
    repeat (cycles) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  int r0, c0, s0, a0;

  initial begin
    // Reset state
    do_reset(3);
    @(negedge clk);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_in_ready", int'(in_ready), 0);
    chk("rst_cs_clr", int'(cs_clr), 1);
    chk("rst_err_short", int'(err_short), 0);
    chk("rst_cs_en", int'(cs_en), 0);
`ifdef CS_CTRL_STATS_EN
    chk("rst_frame_cnt", int'(frame_cnt), 0);
    chk("rst_drop_cnt", int'(drop_cnt), 0);
`endif
    @(posedge clk); #1;
    chk("ready_after_clr", int'(in_ready), 1);

    // 20-sample frame 1..20, downstream always ready: 12 results 45..144
    r0 = n_res; c0 = n_clr; s0 = n_short; got_q.delete();
    send_frame(20, 1, 0, 100);
    wait_drain();
    chk("s1_results", n_res - r0, 12);
    chk("s1_first", got_q[0], 45);
    chk("s1_last", got_q[got_q.size()-1], 144);
    chk("s1_clr_pulses", n_clr - c0, 1);
    chk("s1_short", n_short - s0, 0);

    // Same frame with downstream stalled: 12 accepts then backpressure
    out_pct = 0;
    repeat (2) @(posedge clk); #1;
    r0 = n_res; a0 = n_acc; got_q.delete();
    fork
      send_frame(20, 1, 0, 100);
      begin
        repeat (40) @(negedge clk);
        chk("s2_accepted_at_stall", n_acc - a0, 12);
        chk("s2_in_ready", int'(in_ready), 0);
        chk("s2_out_valid", int'(out_valid), 1);
        chk("s2_results_at_stall", n_res - r0, 0);
        out_pct = 100;
      end
    join
    wait_drain();
    chk("s2_results", n_res - r0, 12);
    chk("s2_first", got_q[0], 45);
    chk("s2_last", got_q[got_q.size()-1], 144);

    // Short frame, then a full frame, then a minimal 9-sample frame
    do_reset(2);
    @(posedge clk); #1;
    r0 = n_res; c0 = n_clr; s0 = n_short;
    send_frame(5, 1, 0, 100);
    wait_drain();
    chk("s3_short", n_short - s0, 1);
    chk("s3_results", n_res - r0, 0);
    chk("s3_clr_pulses", n_clr - c0, 1);
    send_frame(20, 1, 0, 100);
    wait_drain();
`ifdef CS_CTRL_STATS_EN
    chk("s6_frame_cnt", int'(frame_cnt), 2);
    chk("s6_drop_cnt", int'(drop_cnt), 1);
`endif
    r0 = n_res; got_q.delete();
    send_frame(9, 1, 0, 100);
    wait_drain();
    chk("s3_nine_results", n_res - r0, 1);
    chk("s3_nine_value", got_q[0], 45);

    // Random valid/ready, 20 frames of 100 samples
    out_pct = 50;
    r0 = n_res;
    for (int f = 0; f < 20; f++) send_frame(100, 0, 1, 50);
    out_pct = 100;
    wait_drain();
    chk("s4_results", n_res - r0, 1840);

    // Reset mid-RUN with three results queued
    out_pct = 0;
    repeat (2) @(posedge clk); #1;
    for (int i = 0; i < 11; i++) send(8'(i + 1), 1'b0, 100);
    repeat (8) @(posedge clk); #1;
    chk("s5_fifo_model_depth", exp_q.size(), 3);
    chk("s5_out_valid_pre", int'(out_valid), 1);
    out_pct = 100;
    do_reset(1);
    @(negedge clk);
    chk("s5_out_valid", int'(out_valid), 0);
    chk("s5_in_ready", int'(in_ready), 0);
    chk("s5_cs_clr", int'(cs_clr), 1);
    @(posedge clk); #1;
    chk("s5_ready_after", int'(in_ready), 1);
    r0 = n_res; got_q.delete();
    send_frame(9, 10, 0, 100);
    wait_drain();
    chk("s5_results", n_res - r0, 1);
    chk("s5_value", got_q[0], 126);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit, passed %0d of %0d", n_pass, n_tot);
    $fatal(1);
  end

endmodule
